// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants for the 640x480@60 raster.
// Display-side blocks import this package for the active-area bounds
// instead of hard-coding them.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // Default divider: 100 MHz board clock down to a 25 MHz pixel rate
    localparam int unsigned CLK_DIV  = 4;

    // Horizontal segments, in pixels
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;

    // Vertical segments, in lines
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;

    // Derived bounds
    localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned H_START  = H_SYNC + H_BP;
    localparam int unsigned H_END    = H_START + H_ACTIVE - 1;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned V_START  = V_SYNC + V_BP;
    localparam int unsigned V_END    = V_START + V_ACTIVE - 1;

    // Inclusive unsigned range test used for the active-area decode
    function automatic logic in_span(cnt_t x, cnt_t lo, cnt_t hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the timing generator drives it, the
// pixel-painting blocks consume it.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic pix_en;
    cnt_t hCount;
    cnt_t vCount;
    logic hSync;
    logic vSync;
    logic bright;
    logic frame_tick;

    modport master (
        output pix_en, hCount, vCount, hSync, vSync, bright, frame_tick
    );

    modport slave (
        input  pix_en, hCount, vCount, hSync, vSync, bright, frame_tick
    );

endinterface

// File: rtl/vga_timing_gen_pix_en_gen.sv
// Clock divider: produces the combinational pixel-step strike used to
// advance the counters, and a registered one-clk pix_en pulse that lines
// up with the counter update.
module pix_en_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic step_o,
    output logic pix_en_o
);

    // A 1-bit divider is still needed for CLK_DIV=1 so the counter is legal
    localparam int unsigned       DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q;

    assign step_o   = (div_q == DIV_LAST);
    assign pix_en_o = pix_en_q;

    // Next divider value: wrap on the step edge, otherwise count up
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (step_o) div_d = '0;
    end

    // Divider and pix_en registers; pix_en marks the edge the counters moved
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= step_o;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Runs the horizontal/vertical pixel
// counters off the divided pixel step and registers hSync, vSync, bright
// and frame_tick from the next-state counts so every output is aligned
// with the hCount/vCount presented on the same cycle.
module vga_timing_gen
    import vga_timing_pkg::cnt_t, vga_timing_pkg::in_span;
#(
    parameter int unsigned CLK_DIV  = vga_timing_pkg::CLK_DIV,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP
) (
    input  logic            clk,
    input  logic            rst,
    vga_timing_if.master    vga
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned H_END   = H_START + H_ACTIVE - 1;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned V_END   = V_START + V_ACTIVE - 1;

    // Count-width copies of the bounds so every compare is 10-bit unsigned
    localparam cnt_t H_LAST_C  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t H_SYNC_C  = cnt_t'(H_SYNC);
    localparam cnt_t H_START_C = cnt_t'(H_START);
    localparam cnt_t H_END_C   = cnt_t'(H_END);
    localparam cnt_t V_LAST_C  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t V_SYNC_C  = cnt_t'(V_SYNC);
    localparam cnt_t V_START_C = cnt_t'(V_START);
    localparam cnt_t V_END_C   = cnt_t'(V_END);
    localparam cnt_t V_TICK_C  = cnt_t'(V_END + 1);

    logic step;
    logic pix_en;

    cnt_t h_q, h_d;
    cnt_t v_q, v_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic br_q, br_d;
    logic ft_q, ft_d;

    pix_en_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en_gen (
        .clk      (clk),
        .rst      (rst),
        .step_o   (step),
        .pix_en_o (pix_en)
    );

    // Next raster position: advance one pixel per step, wrap line then frame
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (step) begin
            if (h_q == H_LAST_C) begin
                h_d = '0;
                v_d = (v_q == V_LAST_C) ? cnt_t'(0) : v_q + cnt_t'(1);
            end else begin
                h_d = h_q + cnt_t'(1);
            end
        end
    end

    // Decode strobes from the next position so they register alongside it
    always_comb begin
        hs_d = (h_d >= H_SYNC_C);
        vs_d = (v_d >= V_SYNC_C);
        br_d = in_span(h_d, H_START_C, H_END_C) && in_span(v_d, V_START_C, V_END_C);
        // Only the step that lands on the first front-porch line fires the tick
        ft_d = step && (h_d == '0) && (v_d == V_TICK_C);
    end

    // Raster state and registered timing outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            br_q <= 1'b0;
            ft_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            br_q <= br_d;
            ft_q <= ft_d;
        end
    end

    assign vga.pix_en     = pix_en;
    assign vga.hCount     = h_q;
    assign vga.vCount     = v_q;
    assign vga.hSync      = hs_q;
    assign vga.vSync      = vs_q;
    assign vga.bright     = br_q;
    assign vga.frame_tick = ft_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz VGA raster timing that every pixel-painting block in the design consumes. Divides the 100 MHz board clock to a 25 MHz pixel enable, runs the horizontal/vertical counters, and produces hSync, vSync, bright, and a once-per-frame update strobe. Sits between the board clock and the display-side blocks, which decode hCount/vCount/bright into rgb. Active area is hCount 144..783 and vCount 35..514.

## Interface
- CLK_DIV, 4: clk cycles per pixel, ≥1.
- H_SYNC, 96; H_BP, 48; H_ACTIVE, 640; H_FP, 16: horizontal segments in pixels (total 800).
- V_SYNC, 2; V_BP, 33; V_ACTIVE, 480; V_FP, 10: vertical segments in lines (total 525).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- pix_en  out  1  one-clk pulse on the first clk of each pixel.
- hCount  out  10  pixel column, 0..H_TOTAL-1.
- vCount  out  10  line, 0..V_TOTAL-1.
- hSync  out  1  active-low, low while hCount < H_SYNC.
- vSync  out  1  active-low, low while vCount < V_SYNC.
- bright  out  1  high inside the active area.
- frame_tick  out  1  one-clk pulse at start of vertical front porch; game-logic update enable.

## Operation
- Derived constants: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; H_START = H_SYNC+H_BP (144); H_END = H_START+H_ACTIVE-1 (783). Vertical equivalents: V_START 35, V_END 514, V_TOTAL 525.
- Divider div counts 0..CLK_DIV-1. A pixel step occurs on the edge where div == CLK_DIV-1.
- On a pixel step:
  - div wraps to 0 and pix_en is registered to 1. On all other edges pix_en is 0.
  - hCount increments. At H_TOTAL-1 it wraps to 0 and vCount increments.
  - vCount wraps to 0 at V_TOTAL-1 when hCount also wraps.
  - CLK_DIV=1 gives pix_en high continuously after the first edge out of reset.
- hSync, vSync and bright are registered. They are computed from the next count values, so they are always consistent with the hCount/vCount on the same cycle. There is no skew.
- bright = (H_START ≤ hCount ≤ H_END) && (V_START ≤ vCount ≤ V_END).
- frame_tick is registered 1 for exactly one clk, on the pixel step into (hCount=0, vCount=V_END+1). It occurs once per frame.
- Counter widths are 10 bits. Comparisons are unsigned. No count may exceed TOTAL-1.

## Timing
- Reset values: div=0, hCount=0, vCount=0, hSync=0, vSync=0 (counts at 0 lie inside both sync pulses), bright=0, pix_en=0, frame_tick=0.
- After rst deasserts, the first pixel step is on the CLK_DIV-th rising edge. At that edge hCount becomes 1 and pix_en becomes 1.
- Per line: 800 pixel steps, which is 3200 clk at CLK_DIV=4.
- Per frame: 420,000 pixel steps, which is 1,680,000 clk (≈59.5 Hz).
- Horizontal phases:
  - hSync low for hCount 0..95.
  - Back porch 96..143.
  - Active 144..783.
  - Front porch 784..799.
- Vertical phases:
  - vSync low for vCount 0..1.
  - Back porch 2..34.
  - Active 35..514.
  - Front porch 515..524.
- Reset mid-frame forces all outputs to their reset values immediately (asynchronous). Timing restarts from (0,0) with no partial pulse on frame_tick.
- Output latency from counter state to sync/bright is 0 cycles, because both are registered in the same edge.

## Structure
- Package vga_timing_pkg holds:
  - the segment constants;
  - derived H_TOTAL/H_START/H_END/V_TOTAL/V_START/V_END;
  - the 10-bit count width.
- Display-side blocks import the package for their active-area bounds instead of hard-coding 144/35.
- Sub-module pix_en_gen holds the CLK_DIV divider and the pix_en register. Counters and sync/bright/frame_tick logic stay in vga_timing_gen.

## Test plan
- Reset, then release and count clk edges:
  - first pix_en on edge 4, with hCount=1 and vCount=0.
  - pix_en then pulses every 4 clk, one clk wide.
- Run one line:
  - hSync low for exactly 96 pixel steps, high for 704.
  - hCount wraps 799→0 with vCount 0→1 on the same edge.
- Run one full frame:
  - vSync low for exactly 2 lines.
  - bright high for exactly 640×480 = 307,200 pixel steps, first at (144,35) and last at (783,514).
- Check frame_tick:
  - exactly one 1-clk pulse per frame, at (0,515).
  - period between pulses is 1,680,000 clk.
- Assert rst at (400,300) for 3 clk:
  - all outputs reach reset values within the same cycle.
  - after release, the sequence repeats identically to the post-reset case.
- Build with CLK_DIV=1:
  - pix_en constant 1 after the first edge.
  - line length 800 clk, frame 420,000 clk.
